// File: rtl/spi_regbus_arbiter.sv
// rtl/spi_regbus_arbiter.sv - round-robin req/ack arbiter onto one AXI-lite register port
// Optional SPI_ARB_LOCK_EN adds R_LOCK to hold the grant across a multi-access sequence.
module spi_regbus_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                     S_SYSCLK,
  input  logic                     S_RESET,
  input  logic [NREQ-1:0]          R_REQ,
  input  logic [NREQ-1:0]          R_WE,
  input  logic [NREQ*ADDR_W-1:0]   R_ADDR,
  input  logic [NREQ*DATA_W-1:0]   R_WDATA,
`ifdef SPI_ARB_LOCK_EN
  input  logic [NREQ-1:0]          R_LOCK,
`endif
  output logic [NREQ-1:0]          R_ACK,
  output logic [DATA_W-1:0]        R_RDATA,
  output logic                     R_ERR,
  output logic [ADDR_W-1:0]        M_AWADDR,
  output logic                     M_AWVALID,
  input  logic                     M_AWREADY,
  output logic [DATA_W-1:0]        M_WDATA,
  output logic [DATA_W/8-1:0]      M_WSTRB,
  output logic                     M_WVALID,
  input  logic                     M_WREADY,
  input  logic                     M_BVALID,
  output logic                     M_BREADY,
  output logic [ADDR_W-1:0]        M_ARADDR,
  output logic                     M_ARVALID,
  input  logic                     M_ARREADY,
  input  logic [DATA_W-1:0]        M_RDATA,
  input  logic [1:0]               M_RRESP,
  input  logic                     M_RVALID,
  output logic                     M_RREADY
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
`ifdef SPI_ARB_LOCK_EN
  logic                lock_q, lock_d;
`endif

  logic                found;
  logic [PTR_W-1:0]    pick;
  logic                aw_ok;
  logic                w_ok;
  int                  cand;

  // First requester at or above the pointer, wrapping; a live lock overrides the search.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!found && R_REQ[cand]) begin
        found = 1'b1;
        pick  = PTR_W'(cand);
      end
    end
`ifdef SPI_ARB_LOCK_EN
    if (lock_q && R_LOCK[grant_q]) begin
      found = R_REQ[grant_q];
      pick  = grant_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef SPI_ARB_LOCK_EN
    lock_d    = lock_q;
`endif
    R_ACK     = '0;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    aw_ok     = aw_done_q | M_AWREADY;
    w_ok      = w_done_q | M_WREADY;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = pick;
          addr_d    = R_ADDR[pick*ADDR_W +: ADDR_W];
          wdata_d   = R_WDATA[pick*DATA_W +: DATA_W];
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = R_WE[pick] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        M_AWVALID = !aw_done_q;
        M_WVALID  = !w_done_q;
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) state_d = WRESP;
      end
      WRESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) state_d = DONE;
      end
      RADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) state_d = RDATA;
      end
      RDATA: begin
        M_RREADY = 1'b1;
        if (M_RVALID) begin
          rdata_d = M_RDATA;
          err_d   = |M_RRESP;
          state_d = DONE;
        end
      end
      DONE: begin
        R_ACK   = NREQ'(1) << grant_q;
        ptr_d   = (grant_q == PTR_W'(NREQ-1)) ? '0 : grant_q + 1'b1;
`ifdef SPI_ARB_LOCK_EN
        lock_d  = R_LOCK[grant_q];
        if (R_LOCK[grant_q]) ptr_d = grant_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef SPI_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef SPI_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign M_AWADDR = addr_q;
  assign M_ARADDR = addr_q;
  assign M_WDATA  = wdata_q;
  assign M_WSTRB  = '1;
  assign R_RDATA  = rdata_q;
  assign R_ERR    = err_q;

endmodule
